// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - op codes, FSM states and op-class helpers for the load/store unit
package lsu_defs;

  // Operation codes presented on the op port
  localparam logic [2:0] LW  = 3'd0;
  localparam logic [2:0] LH  = 3'd1;
  localparam logic [2:0] LHU = 3'd2;
  localparam logic [2:0] LB  = 3'd3;
  localparam logic [2:0] LBU = 3'd4;
  localparam logic [2:0] SW  = 3'd5;
  localparam logic [2:0] SH  = 3'd6;
  localparam logic [2:0] SB  = 3'd7;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } lsu_state_e;

  // One bit per op code, set when the op belongs to the class
  localparam logic [7:0] STORE_OPS = 8'b1110_0000;
  localparam logic [7:0] HALF_OPS  = 8'b0100_0110;
  localparam logic [7:0] BYTE_OPS  = 8'b1001_1000;
  localparam logic [7:0] WORD_OPS  = 8'b0010_0001;

  function automatic logic is_store(input logic [2:0] op);
    return STORE_OPS[op];
  endfunction

  function automatic logic is_half(input logic [2:0] op);
    return HALF_OPS[op];
  endfunction

  function automatic logic is_byte(input logic [2:0] op);
    return BYTE_OPS[op];
  endfunction

  function automatic logic is_word(input logic [2:0] op);
    return WORD_OPS[op];
  endfunction

endpackage

// File: rtl/load_store_unit_lane.sv
// rtl/load_store_unit_lane.sv - sub-word lane extract/extend for loads and lane merge for stores
module lsu_lane
  import lsu_defs::*;
(
  input  logic [2:0]  op_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] rword_i,
  input  logic [15:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte and halfword out of the little-endian read word
  always_comb begin
    byte_sel = rword_i[7:0];
    case (lane_i)
      2'd0:    byte_sel = rword_i[7:0];
      2'd1:    byte_sel = rword_i[15:8];
      2'd2:    byte_sel = rword_i[23:16];
      default: byte_sel = rword_i[31:24];
    endcase
    half_sel = lane_i[1] ? rword_i[31:16] : rword_i[15:0];
  end

  // Sign- or zero-extend the selected lane; full words pass straight through
  always_comb begin
    load_o = rword_i;
    case (op_i)
      LB:      load_o = {{24{byte_sel[7]}}, byte_sel};
      LBU:     load_o = {24'd0, byte_sel};
      LH:      load_o = {{16{half_sel[15]}}, half_sel};
      LHU:     load_o = {16'd0, half_sel};
      default: load_o = rword_i;
    endcase
  end

  // Overlay store data onto the addressed lane, other lanes keep the read value
  always_comb begin
    merge_o = rword_i;
    if (is_byte(op_i)) begin
      case (lane_i)
        2'd0:    merge_o[7:0]   = wdata_i[7:0];
        2'd1:    merge_o[15:8]  = wdata_i[7:0];
        2'd2:    merge_o[23:16] = wdata_i[7:0];
        default: merge_o[31:24] = wdata_i[7:0];
      endcase
    end else if (is_half(op_i)) begin
      if (lane_i[1]) begin
        merge_o[31:16] = wdata_i;
      end else begin
        merge_o[15:0] = wdata_i;
      end
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - start/done load/store controller driving a word-aligned byte-addressed memory
module load_store_unit
  import lsu_defs::*;
#(
  parameter int ADDR_W      = 32,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              done,
  output logic              err,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [31:0]       mem_d_in,
  output logic              mem_mrd,
  output logic              mem_mwr,
  input  logic [31:0]       mem_d_out
);

  lsu_state_e        state_q;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic [31:0]       mem_d_in_q;
  logic              err_q;

  logic              misalign;
  logic [31:0]       load_val;
  logic [31:0]       merged_word;

  // Flag a misaligned request; with checking off nothing is flagged because the
  // word address and halfword lane select already ignore the low address bits
  always_comb begin
    misalign = 1'b0;
    if (CHECK_ALIGN) begin
      if (is_half(op) && addr[0]) begin
        misalign = 1'b1;
      end
      if (is_word(op) && (addr[1:0] != 2'b00)) begin
        misalign = 1'b1;
      end
    end
  end

  lsu_lane u_lane (
    .op_i    (op_q),
    .lane_i  (addr_q[1:0]),
    .rword_i (mem_d_out),
    .wdata_i (wdata_q),
    .load_o  (load_val),
    .merge_o (merged_word)
  );

  // Controller FSM: accept in IDLE, read and/or write one word, then pulse done
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= 3'd0;
      addr_q     <= '0;
      wdata_q    <= 16'd0;
      rdata_q    <= 32'd0;
      mem_d_in_q <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            op_q    <= op;
            addr_q  <= addr;
            wdata_q <= wdata[15:0];
            err_q   <= misalign;
            if (misalign) begin
              state_q <= ST_DONE;
            end else if (op == SW) begin
              mem_d_in_q <= wdata;
              state_q    <= ST_WRITE;
            end else begin
              state_q <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (is_store(op_q)) begin
            mem_d_in_q <= merged_word;
            state_q    <= ST_WRITE;
          end else begin
            rdata_q <= load_val;
            state_q <= ST_DONE;
          end
        end
        ST_WRITE: begin
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Outputs decoded from the state register; the write strobe is also killed by
  // reset so an aborted store never reaches memory
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign err      = (state_q == ST_DONE) && err_q;
  assign mem_mrd  = (state_q == ST_READ);
  assign mem_mwr  = (state_q == ST_WRITE) && !rst;
  assign mem_adr  = ((state_q == ST_READ) || (state_q == ST_WRITE)) ?
                    {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_d_in = mem_d_in_q;
  assign rdata    = rdata_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator-side controller that drives the byte-addressed data memory (signals mem_adr/mem_d_in/mem_mrd/mem_mwr/mem_d_out) on behalf of the multicycle MIPS datapath.
- Executes LW/LH/LHU/LB/LBU/SW/SH/SB with a start/done handshake.
- Extracts and sign/zero-extends sub-word loads; sub-word stores use read-modify-write.
- All memory accesses are word-aligned, little-endian: byte at adr is bits [7:0].

Parameters:
ADDR_W, 32, width of addr and mem_adr
CHECK_ALIGN, 1, 1 = flag misaligned LH/LHU/SH/LW/SW as error with no memory access; 0 = force-align by clearing low address bits

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous, active-high reset
start  in  1  request strobe, sampled only in IDLE
op  in  3  operation code (lsu_defs)
addr  in  ADDR_W  byte address of access
wdata  in  32  store data, low bytes used for SB/SH
rdata  out  32  extended load result, held until next accepted start
done  out  1  one-cycle completion pulse
err  out  1  misalignment flag, valid only with done
busy  out  1  high in every state except IDLE
mem_adr  out  ADDR_W  word-aligned address to memory, 0 when idle
mem_d_in  out  32  write data to memory
mem_mrd  out  1  memory read enable
mem_mwr  out  1  memory write enable; memory samples it on posedge
mem_d_out  in  32  combinational read data from memory

Behaviour:
- Reset values: rdata=0, done=0, err=0, busy=0, mem_mrd=0, mem_mwr=0, mem_adr=0, mem_d_in=0; state=IDLE.
- In IDLE with start=1: latch op, addr, wdata.
- start in any other state is ignored.
- FSM states: IDLE, READ, WRITE, DONE.
  - IDLE -> READ for loads, SH, SB.
  - IDLE -> WRITE for SW.
  - IDLE -> DONE with err=1 on misalignment (CHECK_ALIGN=1): addr[0]=1 for halfword ops; addr[1:0]!=0 for word ops. Byte ops never misalign.
  - READ -> DONE for loads: rdata <= extracted/extended lane of mem_d_out on the READ edge.
  - READ -> WRITE for SH/SB: captured word merged with wdata lane.
  - WRITE -> DONE.
  - DONE -> IDLE.
- Outputs decoded from state:
  - READ: mem_mrd=1.
  - WRITE: mem_mwr=1.
  - DONE: done=1.
  - mem_adr = {addr[ADDR_W-1:2],2'b00} in READ/WRITE, else 0.
  - mem_mwr is gated with !rst, so a reset in the WRITE cycle suppresses the write.
- Latency in cycles from the start-accept edge to the done cycle:
  - loads = 2
  - SW = 2
  - SH/SB = 3
  - misaligned = 1
- Next start is accepted in the cycle after done.
- Lane selection:
  - byte k = addr[1:0].
  - halfword = addr[1] ? [31:16] : [15:0].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Merge: replace only the addressed byte/halfword lane of the read word with wdata[7:0]/wdata[15:0]; the other lanes are unchanged.
- CHECK_ALIGN=0: low address bits are ignored for word ops; addr[0] is ignored for halfword ops; err is never set.
- Reset mid-operation returns to IDLE next edge. No done pulse and no memory write for the aborted op.
- Store ops leave rdata unchanged.

Decomposition:
- Shared package lsu_defs holds the op codes: LW=3'd0, LH=1, LHU=2, LB=3, LBU=4, SW=5, SH=6, SB=7.
- The package also holds the state encoding and is_store/is_half/is_byte helper constants.
- One combinational sub-module, lsu_lane, handles lane extract/extend for loads and lane merge for stores.
- The FSM and registers stay in load_store_unit.

Test Plan:
- Preload bytes 0x10..0x13 = BB,AA,99,88; LW 0x10 -> done 2 cycles after start, rdata=0x8899AABB, err=0, mem_mwr never high.
- LB 0x13 -> 0xFFFFFF88; LBU 0x13 -> 0x00000088; LH 0x12 -> 0xFFFF8899; LHU 0x10 -> 0x0000AABB.
- SB 0x11 with wdata 0x123456CC -> READ then WRITE at mem_adr 0x10 with mem_d_in=0x8899CCBB, done at start+3; a following LW 0x10 returns 0x8899CCBB.
- SW 0x12 (CHECK_ALIGN=1) -> done=1, err=1 at start+1, mem_mrd/mem_mwr stay 0, memory unchanged; same op with CHECK_ALIGN=0 writes at word 0x10.
- SH 0x12 with rst asserted during the WRITE cycle -> mem_mwr=0 that cycle, memory unchanged, all outputs at reset values next cycle, no done.
- Pulse start during READ of an LW -> ignored; issue a new SW in the cycle after done -> accepted, done 2 cycles later.
